// File: rtl/systolic_array_sequencer_if.sv
// Job-control, operand-buffer and MAC-array signals of the systolic array sequencer.
// master = sequencer side, slave = job controller / operand buffer / array side.
interface systolic_array_sequencer_if #(
    parameter int N        = 16,
    parameter int OP_WIDTH = 8,
    parameter int K_WIDTH  = 16
);
    logic                    start;
    logic [K_WIDTH-1:0]      k_len;
    logic                    busy;
    logic                    done;
    logic                    rd_en;
    logic [K_WIDTH-1:0]      rd_addr;
    logic [N*OP_WIDTH-1:0]   rd_a_column;
    logic [N*OP_WIDTH-1:0]   rd_b_row;
    logic                    array_clear;
    logic [N*OP_WIDTH-1:0]   array_a_column;
    logic [N*OP_WIDTH-1:0]   array_b_row;

    modport master (
        input  start, k_len, rd_a_column, rd_b_row,
        output busy, done, rd_en, rd_addr, array_clear, array_a_column, array_b_row
    );

    modport slave (
        output start, k_len, rd_a_column, rd_b_row,
        input  busy, done, rd_en, rd_addr, array_clear, array_a_column, array_b_row
    );
endinterface

// File: rtl/systolic_array_sequencer.sv
// Sequences one matrix-multiply job: clears the MAC array, streams k_len skewed
// operand pairs into it, waits for the wavefront to drain and pulses done.
module systolic_array_sequencer #(
    parameter int N        = 16,
    parameter int OP_WIDTH = 8,
    parameter int K_WIDTH  = 16
) (
    input  logic                          clk,
    input  logic                          reset,
    systolic_array_sequencer_if.master    bus
);
    localparam logic [K_WIDTH-1:0] DRAIN_LAST = K_WIDTH'(3 * N - 1);

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, DONE} state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [K_WIDTH-1:0]  r_cnt;
    logic [K_WIDTH-1:0]  w_cnt_nxt;
    logic [K_WIDTH-1:0]  r_k_len;
    logic                r_vld_p0;
    logic                w_rd_en;
    logic [K_WIDTH-1:0]  w_rd_addr;
    logic                w_busy;
    logic                w_done;
    logic                w_clear_st;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_k_len  <= '0;
            r_vld_p0 <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_vld_p0 <= w_rd_en;
            if (r_state == IDLE && bus.start)
                r_k_len <= bus.k_len;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_busy      = 1'b1;
        w_done      = 1'b0;
        w_rd_en     = 1'b0;
        w_rd_addr   = '0;
        w_clear_st  = 1'b0;
        case (r_state)
            IDLE: begin
                w_busy    = 1'b0;
                w_cnt_nxt = '0;
                if (bus.start)
                    w_state_nxt = CLEAR;
            end
            CLEAR: begin
                w_clear_st  = 1'b1;
                w_cnt_nxt   = '0;
                w_state_nxt = (r_k_len != '0) ? FEED : DRAIN;
            end
            FEED: begin
                w_rd_en   = 1'b1;
                w_rd_addr = r_cnt;
                if (r_cnt == r_k_len - K_WIDTH'(1)) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DRAIN;
                end else begin
                    w_cnt_nxt = r_cnt + K_WIDTH'(1);
                end
            end
            DRAIN: begin
                if (r_cnt == DRAIN_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt + K_WIDTH'(1);
                end
            end
            DONE: begin
                w_done      = 1'b1;
                w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.busy        = w_busy;
    assign bus.done        = w_done;
    assign bus.rd_en       = w_rd_en;
    assign bus.rd_addr     = w_rd_addr;
    assign bus.array_clear = reset | w_clear_st;

    // Skew: stage 0 captures read data (or a zero bubble), lane g adds g more registers
    for (genvar g = 0; g < N; g++) begin : g_lane
        logic [OP_WIDTH-1:0] r_skew_a [0:g];
        logic [OP_WIDTH-1:0] r_skew_b [0:g];

        always_ff @(posedge clk) begin
            if (reset || w_clear_st) begin
                for (int d = 0; d <= g; d++) begin
                    r_skew_a[d] <= '0;
                    r_skew_b[d] <= '0;
                end
            end else begin
                r_skew_a[0] <= r_vld_p0 ? bus.rd_a_column[g*OP_WIDTH +: OP_WIDTH] : '0;
                r_skew_b[0] <= r_vld_p0 ? bus.rd_b_row[g*OP_WIDTH +: OP_WIDTH]    : '0;
                for (int d = 1; d <= g; d++) begin
                    r_skew_a[d] <= r_skew_a[d-1];
                    r_skew_b[d] <= r_skew_b[d-1];
                end
            end
        end

        assign bus.array_a_column[g*OP_WIDTH +: OP_WIDTH] = r_skew_a[g];
        assign bus.array_b_row[g*OP_WIDTH +: OP_WIDTH]    = r_skew_b[g];
    end
endmodule

// File: tb/tb_systolic_array_sequencer.sv
// Bench for systolic_array_sequencer: operand-buffer responder, behavioural MAC
// array, job scoreboard checked on every done pulse.
module tb_systolic_array_sequencer;
    localparam int N   = 4;
    localparam int OPW = 8;
    localparam int KW  = 16;
    localparam int NB  = N * OPW;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;
    int   n_vec  = 0;
    int   n_miss = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    systolic_array_sequencer_if #(.N(N), .OP_WIDTH(OPW), .K_WIDTH(KW)) bus ();

    systolic_array_sequencer #(.N(N), .OP_WIDTH(OPW), .K_WIDTH(KW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        int k;
        int apat;
        int bpat;
        int lat;
        int mode;
    } vec_t;

    typedef struct {
        int                        done_cyc;
        int                        k;
        logic [N*N-1:0][31:0]      exp_acc;
    } job_t;

    job_t        sb[$];
    job_t        mon_j;
    int          exp_addr = 0;
    int          exp_nz [N];
    int          got_nz [N];
    logic [OPW-1:0] mem_a [16][N];
    logic [OPW-1:0] mem_b [16][N];

    logic [31:0]    acc [N][N];
    logic [OPW-1:0] pa  [N][N];
    logic [OPW-1:0] pb  [N][N];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
        end
    endtask

    // Operand buffer: data one cycle after rd_en, garbage otherwise
    always @(posedge clk) begin
        if (bus.rd_en === 1'b1) begin
            for (int i = 0; i < N; i++) begin
                bus.rd_a_column[i*OPW +: OPW] <= mem_a[bus.rd_addr[3:0]][i];
                bus.rd_b_row[i*OPW +: OPW]    <= mem_b[bus.rd_addr[3:0]][i];
            end
        end else begin
            bus.rd_a_column <= NB'($urandom);
            bus.rd_b_row    <= NB'($urandom);
        end
    end

    // Output-stationary MAC array: A enters row r from the left, B enters column c from the top
    always @(posedge clk) begin
        for (int r = 0; r < N; r++) begin
            for (int c = 0; c < N; c++) begin
                logic [OPW-1:0] ai;
                logic [OPW-1:0] bi;
                if (c == 0) ai = bus.array_a_column[r*OPW +: OPW];
                else        ai = pa[r][c-1];
                if (r == 0) bi = bus.array_b_row[c*OPW +: OPW];
                else        bi = pb[r-1][c];
                if (bus.array_clear === 1'b1) begin
                    pa[r][c]  <= '0;
                    pb[r][c]  <= '0;
                    acc[r][c] <= '0;
                end else begin
                    pa[r][c]  <= ai;
                    pb[r][c]  <= bi;
                    acc[r][c] <= acc[r][c] + 32'(ai) * 32'(bi);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (bus.rd_en === 1'b1) begin
            check("rd_addr", bus.rd_addr, exp_addr);
            exp_addr++;
        end
        for (int i = 0; i < N; i++)
            if (got_nz[i] < 0 && bus.array_a_column[i*OPW +: OPW] != '0)
                got_nz[i] = cyc;
        if (bus.done === 1'b1) begin
            if (sb.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL done_pulse at cycle %0d: got 1, required 0", cyc);
            end else begin
                mon_j = sb.pop_front();
                check("done_cycle", cyc, mon_j.done_cyc);
                check("read_count", exp_addr, mon_j.k);
                for (int r = 0; r < N; r++)
                    for (int c = 0; c < N; c++)
                        check("acc", acc[r][c], mon_j.exp_acc[r*N+c]);
                for (int i = 0; i < N; i++)
                    check("skew_first_nonzero", got_nz[i], exp_nz[i]);
            end
        end
    end

    task automatic fill_mem(input int apat, input int bpat);
        for (int k = 0; k < 16; k++) begin
            for (int l = 0; l < N; l++) begin
                case (apat)
                    0:       mem_a[k][l] = 8'd1;
                    1:       mem_a[k][l] = (l == k) ? 8'd1 : 8'd0;
                    2:       mem_a[k][l] = OPW'(4 * k + l + 1);
                    default: mem_a[k][l] = OPW'($urandom_range(0, 255));
                endcase
                case (bpat)
                    0:       mem_b[k][l] = 8'd1;
                    1:       mem_b[k][l] = (l == k) ? 8'd1 : 8'd0;
                    2:       mem_b[k][l] = OPW'(4 * k + l + 1);
                    default: mem_b[k][l] = OPW'($urandom_range(0, 255));
                endcase
            end
        end
    endtask

    task automatic arm_job(input int k, input int t0, input int lat);
        job_t j;
        j.k        = k;
        j.done_cyc = t0 + lat;
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++) begin
                logic [31:0] s;
                s = 0;
                for (int kk = 0; kk < k; kk++)
                    s = s + 32'(mem_a[kk][r]) * 32'(mem_b[kk][c]);
                j.exp_acc[r*N+c] = s;
            end
        for (int i = 0; i < N; i++) begin
            exp_nz[i] = -1;
            got_nz[i] = -1;
            for (int kk = k - 1; kk >= 0; kk--)
                if (mem_a[kk][i] != '0) exp_nz[i] = t0 + 4 + kk + i;
        end
        exp_addr = 0;
        sb.push_back(j);
    endtask

    // mode 0: single start pulse, 1: start held through DONE, 2: extra pulses during FEED
    task automatic run_job(input int k, input int mode, input int lat);
        int t0;
        int guard;
        @(negedge clk);
        t0 = cyc;
        arm_job(k, t0, lat);
        bus.start = 1'b1;
        bus.k_len = KW'(k);
        @(negedge clk);
        check("busy_in_clear", bus.busy, 1);
        check("array_clear_in_clear", bus.array_clear, 1);
        check("rd_en_in_clear", bus.rd_en, 0);
        bus.k_len = KW'(k + 3);
        if (mode != 1) bus.start = 1'b0;
        guard = 0;
        while (bus.done !== 1'b1 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (mode == 2) bus.start = (guard < 6) ? guard[0] : 1'b0;
        end
        if (guard >= 200) begin
            n_vec++;
            n_miss++;
            $display("FAIL done_timeout k=%0d: got no done, required one by cycle %0d", k, t0 + lat);
            bus.start = 1'b0;
            if (sb.size() != 0) void'(sb.pop_front());
            return;
        end
        @(negedge clk);
        check("busy_after_done", bus.busy, 0);
        bus.start = 1'b0;
        @(negedge clk);
        check("busy_idle", bus.busy, 0);
    endtask

    vec_t tbl [6];

    initial begin
        tbl[0] = '{k: 1, apat: 0, bpat: 0, lat: 15, mode: 0};
        tbl[1] = '{k: 4, apat: 1, bpat: 2, lat: 18, mode: 0};
        tbl[2] = '{k: 0, apat: 0, bpat: 0, lat: 14, mode: 0};
        tbl[3] = '{k: 3, apat: 3, bpat: 3, lat: 17, mode: 0};
        tbl[4] = '{k: 7, apat: 3, bpat: 3, lat: 21, mode: 0};
        tbl[5] = '{k: 2, apat: 2, bpat: 3, lat: 16, mode: 0};
        for (int i = 0; i < N; i++) begin
            exp_nz[i] = -1;
            got_nz[i] = -1;
        end
        bus.start = 1'b0;
        bus.k_len = '0;
        reset     = 1'b1;

        repeat (2) @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_done", bus.done, 0);
        check("reset_rd_en", bus.rd_en, 0);
        check("reset_rd_addr", bus.rd_addr, 0);
        check("reset_array_clear", bus.array_clear, 1);
        check("reset_array_a", bus.array_a_column, 0);
        check("reset_array_b", bus.array_b_row, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_array_clear", bus.array_clear, 0);
        check("idle_busy", bus.busy, 0);

        for (int v = 0; v < 6; v++) begin
            fill_mem(tbl[v].apat, tbl[v].bpat);
            run_job(tbl[v].k, tbl[v].mode, tbl[v].lat);
        end

        fill_mem(3, 3);
        run_job(5, 1, 2 + 5 + 3 * N);
        fill_mem(3, 3);
        run_job(5, 2, 2 + 5 + 3 * N);

        // Reset after the third read of an 8-pair job
        fill_mem(3, 3);
        @(negedge clk);
        exp_addr  = 0;
        bus.start = 1'b1;
        bus.k_len = KW'(8);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midjob_busy", bus.busy, 0);
        check("midjob_rd_en", bus.rd_en, 0);
        check("midjob_done", bus.done, 0);
        check("midjob_array_clear", bus.array_clear, 1);
        check("midjob_array_a", bus.array_a_column, 0);
        check("midjob_array_b", bus.array_b_row, 0);
        check("midjob_reads", exp_addr, 3);
        reset = 1'b0;
        repeat (30) @(negedge clk);
        check("midjob_still_idle", bus.busy, 0);
        fill_mem(3, 2);
        run_job(4, 0, 2 + 4 + 3 * N);

        repeat (5) @(negedge clk);
        check("scoreboard_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
